cpu_if: RTL and testbench

- Instruction fetch stage. Holds the program counter and fetches from instruction memory through a req/ready handshake that tolerates wait states.
- Presents p_pc/p_inst to the decode stage and honours the decode load-use stall.
- Accepts jump/branch redirects from execute and squashes wrong-path fetches by injecting NOPs (32'h0).

---
 rtl/cpu_pkg.sv | 39 +++
 rtl/cpu_if_buf.sv | 33 +++
 rtl/cpu_if.sv | 184 ++++++++++++++++++
 tb/tb_cpu_if.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch/decode definitions: IF FSM encoding, reset defaults, opcodes.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package cpu_pkg;

    // Instruction-fetch FSM encoding (2 bits)
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_FULL  = 2'd2,
        S_KILL  = 2'd3
    } if_state_t;

    // Reset / bubble defaults used as parameter defaults by the fetch stage
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INST = 32'h0000_0000;   // sll $0,$0,0

    localparam logic [31:0] PC_STEP = 32'd4;

    // Opcodes shared with decode
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2b;

    // One fetched word with the PC it came from
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_word_t;

    // Instruction addresses are word aligned; low two bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/cpu_if_buf.sv
// Single-entry pc/inst skid buffer holding a word that arrived behind a stall.
// Latency: 1 cycle from load to valid; clear takes effect next cycle.
// Backpressure: none internally; the owner loads only when empty and clears on use.
//
// Ports: clk, rst (async active-low), load/wr_dat capture a word,
//        clear empties the entry (wins over load), vld/rd_dat present it.
module cpu_if_buf
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  fetch_word_t wr_dat,
    output logic        vld,
    output fetch_word_t rd_dat
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld    <= 1'b0;
            rd_dat <= '0;
        end else if (clear) begin
            // contents zeroed too so a stale target never lingers in the entry
            vld    <= 1'b0;
            rd_dat <= '0;
        end else if (load) begin
            vld    <= 1'b1;
            rd_dat <= wr_dat;
        end
    end

endmodule

// File: rtl/cpu_if.sv
// Instruction fetch stage: PC, imem req/ready fetch, decode handoff, redirect squash.
// Latency: 1 cycle from imem_ready to p_pc/p_inst; zero-wait memory sustains 1 inst/cycle.
// Backpressure: decode stall holds p_*; one word parks in a skid buffer and requests pause.
//
// Ports: clk/rst (async active-low); stall from decode; redirect/redirect_pc from
//        execute; imem_req/imem_addr/imem_rdata/imem_ready memory handshake;
//        p_pc/p_inst to decode.
// Optional: define CPU_IF_PERF_EN to add perf_fetched/perf_wait/perf_kill counters.
module cpu_if
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] p_pc,
`ifdef CPU_IF_PERF_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_wait,
    output logic [31:0] perf_kill,
`endif
    output logic [31:0] p_inst
);

    if_state_t   state;
    logic [31:0] pc;
    logic [31:0] saved_pc;      // redirect target parked while a wrong-path request drains
    logic [31:0] tgt;

    fetch_word_t buf_wr;
    fetch_word_t buf_rd;
    logic        buf_vld;
    logic        buf_load;
    logic        buf_clear;

    assign tgt = word_align(redirect_pc);

    // The address register is the PC itself: it only moves when a request
    // retires (or from S_FULL/S_IDLE where nothing is outstanding), so the
    // address is stable for the whole life of a request, including in S_KILL.
    assign imem_addr = pc;

    always_comb begin
        buf_load     = (state == S_FETCH) && imem_ready && stall && !redirect;
        buf_clear    = (state == S_FULL) && (redirect || !stall);
        buf_wr.pc    = pc;
        buf_wr.inst  = imem_rdata;
    end

    cpu_if_buf u_buf (
        .clk    (clk),
        .rst    (rst),
        .load   (buf_load),
        .clear  (buf_clear),
        .wr_dat (buf_wr),
        .vld    (buf_vld),
        .rd_dat (buf_rd)
    );

    // Priority inside every state: redirect > stall > normal flow.
    // imem_req is registered and tracks state in {S_FETCH, S_KILL}; the async
    // reset clears it immediately, abandoning any outstanding request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            pc       <= word_align(RESET_PC);
            saved_pc <= '0;
            p_pc     <= '0;
            p_inst   <= NOP_INST;
            imem_req <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (redirect) begin
                        pc     <= tgt;
                        p_inst <= NOP_INST;
                    end
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                end

                S_FETCH: begin
                    if (redirect) begin
                        p_inst <= NOP_INST;
                        if (imem_ready) begin
                            pc <= tgt;              // returned word is wrong-path
                        end else begin
                            saved_pc <= tgt;        // must let the old request finish
                            state    <= S_KILL;
                        end
                    end else if (stall) begin
                        if (imem_ready) begin
                            pc       <= pc + PC_STEP;
                            state    <= S_FULL;
                            imem_req <= 1'b0;
                        end
                    end else if (imem_ready) begin
                        p_pc   <= pc;
                        p_inst <= imem_rdata;
                        pc     <= pc + PC_STEP;
                    end else begin
                        p_inst <= NOP_INST;
                    end
                end

                S_FULL: begin
                    if (redirect) begin
                        p_inst   <= NOP_INST;
                        pc       <= tgt;
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                    end else if (!stall && buf_vld) begin
                        // hand the parked word over and restart fetching at once
                        p_pc     <= buf_rd.pc;
                        p_inst   <= buf_rd.inst;
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                    end
                end

                S_KILL: begin
                    if (redirect) begin
                        p_inst <= NOP_INST;
                        if (imem_ready) begin
                            pc    <= tgt;
                            state <= S_FETCH;
                        end else begin
                            saved_pc <= tgt;        // newest redirect wins
                        end
                    end else begin
                        if (!stall) begin
                            p_inst <= NOP_INST;
                        end
                        if (imem_ready) begin
                            pc    <= saved_pc;
                            state <= S_FETCH;
                        end
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef CPU_IF_PERF_EN
    logic fetch_keep;
    logic fetch_drop;

    assign fetch_keep = (state == S_FETCH) && imem_ready && !redirect;
    assign fetch_drop = ((state == S_FETCH) && imem_ready && redirect) ||
                        ((state == S_KILL) && imem_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched <= '0;
            perf_wait    <= '0;
            perf_kill    <= '0;
        end else begin
            if (fetch_keep) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (imem_req && !imem_ready) begin
                perf_wait <= perf_wait + 32'd1;
            end
            if (fetch_drop) begin
                perf_kill <= perf_kill + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cpu_if.sv
// Self-checking bench for the cpu_if fetch stage: directed scenarios plus a random run.
// Latency: n/a (testbench).
// Backpressure: memory ready and decode stall are driven by the bench.
module tb_cpu_if;

    localparam logic [31:0] KEY = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] p_pc;
    logic [31:0] p_inst;

    logic        ready_drv = 1'b1;
    logic [31:0] junk = 32'hDEAD_BEEF;

    int total = 0;
    int bad = 0;

    // Memory model: word at address A is A ^ KEY; bus carries junk when not ready.
    assign imem_ready = ready_drv;
    assign imem_rdata = ready_drv ? (imem_addr ^ KEY) : junk;

    always #5 clk = ~clk;

    cpu_if dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .p_pc        (p_pc),
        .p_inst      (p_inst)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; ready_drv = 1'b1;
        rst = 1'b0;
        step; step;
        rst = 1'b1;
    endtask

    task automatic run_to(input logic [31:0] a, input string nm);
        int n;
        n = 0;
        while (imem_addr !== a && n < 300) begin
            step;
            n++;
        end
        total++;
        if (imem_addr !== a) begin bad++; $display("FAIL %s_reach addr got=%h exp=%h", nm, imem_addr, a); end
    endtask

    task automatic test_reset;
        #3 rst = 1'b0;
        #1;
        total++; if (p_pc !== 32'h0) begin bad++; $display("FAIL reset_p_pc got=%h exp=%h", p_pc, 32'h0); end
        total++; if (p_inst !== 32'h0) begin bad++; $display("FAIL reset_p_inst got=%h exp=%h", p_inst, 32'h0); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, 32'h0); end
        step;
        rst = 1'b1;
        step;   // idle cycle edge: request starts now
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL idle_to_fetch_req got=%b exp=1", imem_req); end
        total++; if (p_inst !== 32'h0) begin bad++; $display("FAIL idle_p_inst got=%h exp=%h", p_inst, 32'h0); end
        for (int k = 0; k < 6; k++) begin
            step;
            total++; if (p_pc !== 32'(4 * k)) begin bad++; $display("FAIL stream_p_pc got=%h exp=%h", p_pc, 32'(4 * k)); end
            total++; if (p_inst !== (32'(4 * k) ^ KEY)) begin bad++; $display("FAIL stream_p_inst got=%h exp=%h", p_inst, 32'(4 * k) ^ KEY); end
            total++; if (imem_addr !== 32'(4 * k + 4)) begin bad++; $display("FAIL stream_addr got=%h exp=%h", imem_addr, 32'(4 * k + 4)); end
        end
    endtask

    task automatic test_wait_state;
        do_reset;
        run_to(32'h10, "wait");
        ready_drv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step;
            total++; if (imem_addr !== 32'h10) begin bad++; $display("FAIL wait_addr got=%h exp=%h", imem_addr, 32'h10); end
            total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL wait_req got=%b exp=1", imem_req); end
            total++; if (p_inst !== 32'h0) begin bad++; $display("FAIL wait_bubble got=%h exp=%h", p_inst, 32'h0); end
        end
        ready_drv = 1'b1;
        step;
        total++; if (p_pc !== 32'h10) begin bad++; $display("FAIL wait_done_p_pc got=%h exp=%h", p_pc, 32'h10); end
        total++; if (p_inst !== (32'h10 ^ KEY)) begin bad++; $display("FAIL wait_done_p_inst got=%h exp=%h", p_inst, 32'h10 ^ KEY); end
        total++; if (imem_addr !== 32'h14) begin bad++; $display("FAIL wait_done_addr got=%h exp=%h", imem_addr, 32'h14); end
    endtask

    task automatic test_stall;
        run_to(32'h20, "stall");
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step;
            total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_req got=%b exp=0", imem_req); end
            total++; if (p_pc !== 32'h1C) begin bad++; $display("FAIL stall_hold_pc got=%h exp=%h", p_pc, 32'h1C); end
            total++; if (p_inst !== (32'h1C ^ KEY)) begin bad++; $display("FAIL stall_hold_inst got=%h exp=%h", p_inst, 32'h1C ^ KEY); end
        end
        stall = 1'b0;
        step;
        total++; if (p_pc !== 32'h20) begin bad++; $display("FAIL stall_buf_pc got=%h exp=%h", p_pc, 32'h20); end
        total++; if (p_inst !== (32'h20 ^ KEY)) begin bad++; $display("FAIL stall_buf_inst got=%h exp=%h", p_inst, 32'h20 ^ KEY); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h24) begin bad++; $display("FAIL stall_restart got=%b/%h exp=1/%h", imem_req, imem_addr, 32'h24); end
        step;
        total++; if (p_pc !== 32'h24) begin bad++; $display("FAIL stall_next_pc got=%h exp=%h", p_pc, 32'h24); end
    endtask

    task automatic test_redirect_kill;
        run_to(32'h40, "kill");
        ready_drv = 1'b0;
        step;
        total++; if (p_inst !== 32'h0) begin bad++; $display("FAIL kill_wait_bubble got=%h exp=%h", p_inst, 32'h0); end
        redirect = 1'b1; redirect_pc = 32'h103;
        step;
        redirect = 1'b0;
        total++; if (imem_addr !== 32'h40 || imem_req !== 1'b1) begin bad++; $display("FAIL kill_old_addr got=%b/%h exp=1/%h", imem_req, imem_addr, 32'h40); end
        total++; if (p_inst !== 32'h0 || p_pc !== 32'h3C) begin bad++; $display("FAIL kill_redirect_p got=%h/%h exp=%h/%h", p_pc, p_inst, 32'h3C, 32'h0); end
        step;
        total++; if (imem_addr !== 32'h40) begin bad++; $display("FAIL kill_stable got=%h exp=%h", imem_addr, 32'h40); end
        ready_drv = 1'b1;
        step;   // wrong-path word retires and is dropped
        total++; if (p_inst !== 32'h0) begin bad++; $display("FAIL kill_discard got=%h exp=%h", p_inst, 32'h0); end
        total++; if (imem_addr !== 32'h100 || imem_req !== 1'b1) begin bad++; $display("FAIL kill_target got=%b/%h exp=1/%h", imem_req, imem_addr, 32'h100); end
        step;
        total++; if (p_pc !== 32'h100 || p_inst !== (32'h100 ^ KEY)) begin bad++; $display("FAIL kill_first got=%h/%h exp=%h/%h", p_pc, p_inst, 32'h100, 32'h100 ^ KEY); end
    endtask

    task automatic test_redirect_full;
        run_to(32'h130, "full");
        stall = 1'b1;
        step;
        redirect = 1'b1; redirect_pc = 32'h200;
        step;
        redirect = 1'b0; stall = 1'b0;
        total++; if (p_inst !== 32'h0 || p_pc !== 32'h12C) begin bad++; $display("FAIL full_redir_p got=%h/%h exp=%h/%h", p_pc, p_inst, 32'h12C, 32'h0); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin bad++; $display("FAIL full_redir_req got=%b/%h exp=1/%h", imem_req, imem_addr, 32'h200); end
        step;
        total++; if (p_pc !== 32'h200 || p_inst !== (32'h200 ^ KEY)) begin bad++; $display("FAIL full_redir_first got=%h/%h exp=%h/%h", p_pc, p_inst, 32'h200, 32'h200 ^ KEY); end
    endtask

    task automatic test_wrap_and_reset;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step;
        redirect = 1'b0;
        total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr got=%h exp=%h", imem_addr, 32'hFFFF_FFFC); end
        step;
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_next got=%h exp=%h", imem_addr, 32'h0); end
        total++; if (p_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_p_pc got=%h exp=%h", p_pc, 32'hFFFF_FFFC); end
        ready_drv = 1'b0;
        step;
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL midwait_req got=%b exp=1", imem_req); end
        #2 rst = 1'b0;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL async_req_drop got=%b exp=0", imem_req); end
        total++; if (p_pc !== 32'h0 || p_inst !== 32'h0) begin bad++; $display("FAIL async_p got=%h/%h exp=0/0", p_pc, p_inst); end
    endtask

    // Random run: program-order scoreboard. Each newly presented word must be
    // the next address in program order (restarting at the latest redirect
    // target) and carry that address's memory word.
    task automatic test_random;
        localparam int N = 1500;
        logic        s, r, rd;
        logic [31:0] t, o_pc, o_inst, o_addr, exp_next;
        logic        o_req;
        int          tail_pres;
        do_reset;
        exp_next  = 32'h0;
        tail_pres = 0;
        for (int cyc = 0; cyc < N; cyc++) begin
            if (cyc < N - 20) begin
                s  = ($urandom_range(0, 3) == 0);
                r  = ($urandom_range(0, 11) == 0);
                rd = ($urandom_range(0, 9) < 7);
                t  = 32'($urandom_range(0, 4095));
            end else begin
                s = 1'b0; r = 1'b0; rd = 1'b1; t = 32'h0;
            end
            stall = s; redirect = r; redirect_pc = t; ready_drv = rd; junk = $urandom;
            o_pc = p_pc; o_inst = p_inst; o_addr = imem_addr; o_req = imem_req;
            step;
            if (o_req && !rd) begin
                total++; if (imem_addr !== o_addr) begin bad++; $display("FAIL rnd_addr_stable cyc=%0d got=%h exp=%h", cyc, imem_addr, o_addr); end
            end
            if (r) begin
                total++; if (p_inst !== 32'h0 || p_pc !== o_pc) begin bad++; $display("FAIL rnd_redirect cyc=%0d got=%h/%h exp=%h/0", cyc, p_pc, p_inst, o_pc); end
                exp_next = t & 32'hFFFF_FFFC;
            end else if (s) begin
                total++; if (p_pc !== o_pc || p_inst !== o_inst) begin bad++; $display("FAIL rnd_stall_hold cyc=%0d got=%h/%h exp=%h/%h", cyc, p_pc, p_inst, o_pc, o_inst); end
            end else if (p_inst !== 32'h0 && p_inst !== o_inst) begin
                total++; if (p_pc !== exp_next || p_inst !== (exp_next ^ KEY)) begin bad++; $display("FAIL rnd_order cyc=%0d got=%h/%h exp=%h/%h", cyc, p_pc, p_inst, exp_next, exp_next ^ KEY); end
                exp_next = p_pc + 32'd4;
                if (cyc >= N - 10) tail_pres++;
            end
        end
        total++; if (tail_pres != 10) begin bad++; $display("FAIL rnd_tail_throughput got=%0d exp=%0d", tail_pres, 10); end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_wait_state;
        test_stall;
        test_redirect_kill;
        test_redirect_full;
        test_wrap_and_reset;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
